reg8_serial_loader: RTL
=======================

REG8_SERIAL_LOADER -- requirements
Module: reg8_serial_loader

Interface
REQ-001 Parameter PARITY_EN, default 1, meaning: 1 = even-parity bit expected after data, 0 = no parity bit in the frame.
REQ-002 clk  input  1  meaning: single clock; all state updates on posedge clk.
REQ-003 rst  input  1  meaning: reset, asynchronous, active-low (asserted when 0).
REQ-004 sdi  input  1  meaning: serial data bit.
REQ-005 sen  input  1  meaning: bit-valid qualifier; sdi is sampled only on posedge clk with sen=1.
REQ-006 abort  input  1  meaning: synchronous frame abort, active-high.
REQ-007 din  output  8  meaning: assembled byte, registered; feeds the 8-bit register data input.
REQ-008 w  output  1  meaning: one-cycle write strobe; feeds the 8-bit register write enable.
REQ-009 busy  output  1  meaning: 1 while a frame is in progress (state != IDLE).
REQ-010 perr  output  1  meaning: one-cycle parity-error pulse.

Function
REQ-011 The FSM SHALL have the states IDLE, DATA and PAR (PAR is used only when PARITY_EN=1).
REQ-012 IDLE: a sampled bit with sen=1 and sdi=0 (start bit) SHALL move the FSM to DATA and clear the 3-bit bit counter; sen=1 with sdi=1 SHALL keep the FSM in IDLE.
REQ-013 DATA: each sampled bit SHALL be shifted into an internal shift register LSB-first (first data bit becomes bit 0), and the counter SHALL increment.
REQ-014 The cycle that samples the 8th data bit (counter=7) SHALL go to PAR if PARITY_EN=1, else complete the frame.
REQ-015 PAR: the sampled bit SHALL complete the frame; the frame is valid when the XOR of the 8 data bits and the parity bit is 0.
REQ-016 Cycles with sen=0 SHALL hold state, counter and shift register unchanged (stall), with no timeout.
REQ-017 On valid frame completion, din SHALL load the shift register and w SHALL be 1 in the following cycle only.
REQ-018 On a parity failure, din SHALL keep its previous value, w SHALL stay 0, and perr SHALL be 1 in the following cycle only.
REQ-019 Frame completion SHALL return the FSM to IDLE in the same edge, so a start bit sampled in the cycle w/perr is high SHALL begin a new frame (back-to-back frames, no gap required).
REQ-020 w and perr SHALL never be 1 in the same cycle; each SHALL be 0 except for the single pulse.
REQ-021 abort=1 SHALL force IDLE and clear the counter at the next edge, SHALL take priority over sen/sdi, SHALL leave din unchanged, and SHALL produce no w/perr pulse.
REQ-022 busy SHALL be a registered decode of state (0 in IDLE), and SHALL not be asserted during the w pulse cycle unless a new start bit was sampled at that edge.
REQ-023 din SHALL change only on a valid frame completion or reset.

Reset
REQ-024 While rst=0, immediately and independent of clk, the block SHALL hold state=IDLE, counter=0, shift register=0x00, din=0x00, w=0, perr=0, busy=0.
REQ-025 Deassertion of rst SHALL take effect at the first posedge clk with rst=1; a frame in progress when rst asserts SHALL be discarded with no w pulse.

Verification
REQ-026 PARITY_EN=1: start bit, then data 0xA5 sent LSB-first (1,0,1,0,0,1,0,1), then parity 0, sen=1 on every cycle -> exactly one w pulse, din=0xA5 from that cycle onward, perr=0.
REQ-027 Same frame with parity 1 -> perr pulses once, w stays 0, din keeps its prior value (0x00 after reset).
REQ-028 0x3C frame with sen=0 inserted for 3 cycles between data bits 4 and 5 -> busy held high through the stall, din=0x3C, w pulse arrives 3 cycles later than the unstalled case.
REQ-029 Two back-to-back frames 0x01 then 0xFF, with the second start bit in the w cycle of the first -> two w pulses 10 cycles apart, din=0x01 then 0xFF.
REQ-030 abort=1 after 4 data bits, then a full 0x5A frame -> no pulse for the aborted frame, one w pulse with din=0x5A; repeat with rst=0 mid-frame -> outputs go to reset values asynchronously and no w pulse.
REQ-031 PARITY_EN=0: start bit plus 8 data bits of 0x80 -> w pulses in the cycle after the 8th data bit, din=0x80, perr never asserted.

Source files
------------

// File: rtl/reg8_serial_loader.sv
// Serial-to-parallel loader for an 8-bit register.
// Frames are a start bit (sdi=0), eight data bits LSB-first and, when
// PARITY_EN=1, an even-parity bit. Only cycles with sen=1 advance the frame.
// A good frame loads din and pulses w; a parity failure pulses perr instead.
module reg8_serial_loader #(
   parameter int PARITY_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sdi,
   input  logic       sen,
   input  logic       abort,
   output logic [7:0] din,
   output logic       w,
   output logic       busy,
   output logic       perr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_e;

   localparam logic PAR_ON = (PARITY_EN != 32'sd0);

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [7:0] sh_q;
   logic [7:0] din_q;
   logic       w_q;
   logic       perr_q;
   logic       busy_q;
   logic [7:0] sh_d;

   // Even parity over data plus parity bit: a good frame XORs to zero.
   function automatic logic even_parity_ok(input logic [7:0] data, input logic pbit);
      return ~(^{data, pbit});
   endfunction

   // Shift register value after sampling the current bit (new bit enters at the MSB,
   // so after eight shifts the first bit sits in bit 0).
   always_comb begin
      sh_d = {sdi, sh_q[7:1]};
   end

   // Frame FSM with registered strobes; abort outranks any sampled bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         sh_q    <= 8'h00;
         din_q   <= 8'h00;
         w_q     <= 1'b0;
         perr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         w_q    <= 1'b0;
         perr_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
         end else if (sen) begin
            case (state_q)
               IDLE: begin
                  if (!sdi) begin
                     state_q <= DATA;
                     cnt_q   <= 3'd0;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               DATA: begin
                  sh_q  <= sh_d;
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (PAR_ON) begin
                        state_q <= PAR;
                        busy_q  <= 1'b1;
                     end else begin
                        // No parity bit: the eighth data bit completes the frame.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        din_q   <= sh_d;
                        w_q     <= 1'b1;
                     end
                  end else begin
                     state_q <= DATA;
                     busy_q  <= 1'b1;
                  end
               end
               PAR: begin
                  // Return to IDLE on this edge so the next start bit can follow at once.
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (even_parity_ok(sh_q, sdi)) begin
                     din_q <= sh_q;
                     w_q   <= 1'b1;
                  end else begin
                     perr_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
                  busy_q  <= 1'b0;
               end
            endcase
         end else begin
            // Stall: hold everything until the next qualified bit.
            state_q <= state_q;
         end
      end
   end

   assign din  = din_q;
   assign w    = w_q;
   assign perr = perr_q;
   assign busy = busy_q;

endmodule
